// File: rtl/pong_match_ctrl_if.sv
// Pong match controller signal bundle.
// Carries the frame tick, player inputs, ball-miss pulses and the match
// outputs (recenter strobe, ball enable, serve direction, scores, winner,
// debug state) between the match controller and the rest of the game.
// The master side is the match controller; the slave side is the
// environment (buttons, paddle movers, ball mover, display).
interface pong_match_ctrl_if #(
  parameter int SCORE_W = 4
) ();

  logic               tick;
  logic               start_n;
  logic               miss_l;
  logic               miss_r;
  logic               recenter;
  logic               ball_en;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic [1:0]         winner;
  logic [2:0]         state_o;

  modport master (
    input  tick,
    input  start_n,
    input  miss_l,
    input  miss_r,
    output recenter,
    output ball_en,
    output serve_dir,
    output score_l,
    output score_r,
    output winner,
    output state_o
  );

  modport slave (
    output tick,
    output start_n,
    output miss_l,
    output miss_r,
    input  recenter,
    input  ball_en,
    input  serve_dir,
    input  score_l,
    input  score_r,
    input  winner,
    input  state_o
  );

endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve timing, scoring, win detection.
// Drives the paddle/ball recenter strobe, the ball enable and the serve
// direction. All delays advance only on the frame tick.
// Optional feature macro: PONG_AUTO_RESTART_EN -- when defined, GAME_OVER
// restarts the match by itself after OVER_TICKS frame ticks; when not
// defined, GAME_OVER waits for a start button press.
module pong_match_ctrl #(
  parameter int WIN_SCORE   = 7,
  parameter int SCORE_W     = 4,
  parameter int SERVE_TICKS = 120,
  parameter int OVER_TICKS  = 300
) (
  input logic               clock,
  input logic               reset,
  pong_match_ctrl_if.master bus
);

  // One counter serves both the serve delay and the game-over delay, so it
  // is sized for the longer of the two.
  localparam int CNT_MAX = (SERVE_TICKS > OVER_TICKS) ? SERVE_TICKS : OVER_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
`ifdef PONG_AUTO_RESTART_EN
  localparam logic [CNT_W-1:0]   OVER_LAST  = CNT_W'(OVER_TICKS - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  // Registered state and outputs
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [SCORE_W-1:0] r_score_l;
  logic [SCORE_W-1:0] r_score_r;
  logic               r_serve_dir;
  logic [1:0]         r_winner;
  logic               r_recenter;
  logic               r_ball_en;

  // Start button edge detector
  logic               r_start_prev;
  logic               r_armed;
  logic               w_start_edge;

  // Next-state values
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [SCORE_W-1:0] w_score_l_nxt;
  logic [SCORE_W-1:0] w_score_r_nxt;
  logic               w_serve_dir_nxt;
  logic [1:0]         w_winner_nxt;
  logic               w_recenter_nxt;
  logic               w_do_start;

  // Scores stop at the winning value and never wrap.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= WIN_VAL) ? s : s + SCORE_W'(1);
  endfunction

  // A press is a 1->0 transition of start_n. r_armed stays low after reset
  // until the button has been seen released, so a button held down across
  // reset release cannot launch a match on its own.
  assign w_start_edge = r_armed & r_start_prev & ~bus.start_n;

  // Track the previous button level and whether it has been seen released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_start_prev <= 1'b1;
      r_armed      <= 1'b0;
    end else begin
      r_start_prev <= bus.start_n;
      r_armed      <= r_armed | bus.start_n;
    end
  end

  // Next-state, counter, scoring and strobe decisions.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_score_l_nxt   = r_score_l;
    w_score_r_nxt   = r_score_r;
    w_serve_dir_nxt = r_serve_dir;
    w_winner_nxt    = r_winner;
    w_recenter_nxt  = 1'b0;
    w_do_start      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_do_start = 1'b1;
        end
      end

      S_SERVE: begin
        // Misses are ignored while the ball is parked.
        if (bus.tick) begin
          if (r_cnt == SERVE_LAST) begin
            w_state_nxt = S_PLAY;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
      end

      S_PLAY: begin
        // The serve goes toward the player who lost the point. A double
        // miss is a let: no score, serve direction kept.
        if (bus.miss_l && bus.miss_r) begin
          w_state_nxt     = S_POINT;
        end else if (bus.miss_l) begin
          w_score_r_nxt   = sat_inc(r_score_r);
          w_serve_dir_nxt = 1'b0;
          w_state_nxt     = S_POINT;
        end else if (bus.miss_r) begin
          w_score_l_nxt   = sat_inc(r_score_l);
          w_serve_dir_nxt = 1'b1;
          w_state_nxt     = S_POINT;
        end
        if (w_state_nxt == S_POINT) begin
          w_recenter_nxt = 1'b1;
        end
      end

      S_POINT: begin
        if (r_score_l == WIN_VAL) begin
          w_winner_nxt = 2'b01;
          w_state_nxt  = S_OVER;
        end else if (r_score_r == WIN_VAL) begin
          w_winner_nxt = 2'b10;
          w_state_nxt  = S_OVER;
        end else begin
          w_cnt_nxt    = '0;
          w_state_nxt  = S_SERVE;
        end
      end

      S_OVER: begin
        // Scores and winner are held for display until the next match.
        if (w_start_edge) begin
          w_do_start = 1'b1;
        end
`ifdef PONG_AUTO_RESTART_EN
        else if (bus.tick) begin
          if (r_cnt == OVER_LAST) begin
            w_do_start = 1'b1;
          end else begin
            w_cnt_nxt  = r_cnt + CNT_W'(1);
          end
        end
`endif
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // New match: fresh scores, serve to the left, recenter everything.
    if (w_do_start) begin
      w_score_l_nxt   = '0;
      w_score_r_nxt   = '0;
      w_winner_nxt    = 2'b00;
      w_serve_dir_nxt = 1'b0;
      w_recenter_nxt  = 1'b1;
      w_cnt_nxt       = '0;
      w_state_nxt     = S_SERVE;
    end
  end

  // State register and registered outputs; ball_en follows the next state
  // so it is high exactly while the FSM sits in PLAY.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_score_l   <= '0;
      r_score_r   <= '0;
      r_serve_dir <= 1'b0;
      r_winner    <= 2'b00;
      r_recenter  <= 1'b0;
      r_ball_en   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_score_l   <= w_score_l_nxt;
      r_score_r   <= w_score_r_nxt;
      r_serve_dir <= w_serve_dir_nxt;
      r_winner    <= w_winner_nxt;
      r_recenter  <= w_recenter_nxt;
      r_ball_en   <= (w_state_nxt == S_PLAY);
    end
  end

  assign bus.recenter  = r_recenter;
  assign bus.ball_en   = r_ball_en;
  assign bus.serve_dir = r_serve_dir;
  assign bus.score_l   = r_score_l;
  assign bus.score_r   = r_score_r;
  assign bus.winner    = r_winner;
  assign bus.state_o   = r_state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Testbench for pong_match_ctrl (WIN_SCORE=3, SERVE_TICKS=120, OVER_TICKS=5).
// Every recenter pulse and every rising edge of ball_en is an output event;
// the stimulus queues the expected snapshot of all outputs for each event
// and a monitor pops and compares on the falling clock edge.
module tb_pong_match_ctrl;

  localparam int SW  = 4;
  localparam int WIN = 3;
  localparam int ST  = 120;
  localparam int OT  = 5;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  pong_match_ctrl_if #(.SCORE_W(SW)) bus ();

  pong_match_ctrl #(
    .WIN_SCORE  (WIN),
    .SCORE_W    (SW),
    .SERVE_TICKS(ST),
    .OVER_TICKS (OT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  typedef struct packed {
    logic [2:0]    st;
    logic [SW-1:0] sl;
    logic [SW-1:0] sr;
    logic          sdir;
    logic [1:0]    win;
    logic          be;
    logic          rc;
  } snap_t;

  snap_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic snap_t mk(input logic [2:0] st, input logic [SW-1:0] sl,
                               input logic [SW-1:0] sr, input logic sdir,
                               input logic [1:0] win, input logic be, input logic rc);
    snap_t s;
    s.st = st; s.sl = sl; s.sr = sr; s.sdir = sdir; s.win = win; s.be = be; s.rc = rc;
    return s;
  endfunction

  function automatic snap_t cur();
    return mk(bus.state_o, bus.score_l, bus.score_r, bus.serve_dir,
              bus.winner, bus.ball_en, bus.recenter);
  endfunction

  // Monitor: compare every output event against the scoreboard.
  initial begin
    logic  pb;
    snap_t got;
    snap_t e;
    pb = 1'b0;
    forever begin
      @(negedge clock);
      if (reset !== 1'b0) begin
        pb = 1'b0;
      end else begin
        if (bus.recenter || (bus.ball_en && !pb)) begin
          got = cur();
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got %h, expected no event at %0t", got, $time);
          end else begin
            e = exp_q.pop_front();
            chk("event", 32'(got), 32'(e));
          end
        end
        pb = bus.ball_en;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Called one cycle into SERVE (counter at 0); releases the ball.
  task automatic serve_to_play(input logic [SW-1:0] sl, input logic [SW-1:0] sr,
                               input logic sdir);
    exp_q.push_back(mk(3'd2, sl, sr, sdir, 2'b00, 1'b1, 1'b0));
    bus.tick = 1'b1;
    step(ST - 1);
    chk("serve_hold_state", 32'(bus.state_o), 1);
    chk("serve_hold_ball_en", 32'(bus.ball_en), 0);
    step(1);
    bus.tick = 1'b0;
    chk("play_state", 32'(bus.state_o), 2);
    chk("play_ball_en", 32'(bus.ball_en), 1);
  endtask

  initial begin
    reset       = 1'b1;
    bus.tick    = 1'b0;
    bus.start_n = 1'b1;
    bus.miss_l  = 1'b0;
    bus.miss_r  = 1'b0;
    step(3);
    chk("rst_state", 32'(bus.state_o), 0);
    chk("rst_outputs", 32'(cur()), 32'(mk(3'd0, '0, '0, 1'b0, 2'b00, 1'b0, 1'b0)));
    reset = 1'b0;
    step(2);

    // Start press; held low afterwards must not retrigger.
    exp_q.push_back(mk(3'd1, '0, '0, 1'b0, 2'b00, 1'b0, 1'b1));
    bus.start_n = 1'b0;
    step(1);
    serve_to_play('0, '0, 1'b0);

    // Right player misses: point to left, serve toward right.
    exp_q.push_back(mk(3'd3, SW'(1), '0, 1'b1, 2'b00, 1'b0, 1'b1));
    bus.miss_r = 1'b1;
    step(1);
    bus.miss_r = 1'b0;
    chk("point_state", 32'(bus.state_o), 3);
    step(1);
    chk("after_point_state", 32'(bus.state_o), 1);
    chk("after_point_recenter", 32'(bus.recenter), 0);
    chk("after_point_ball_en", 32'(bus.ball_en), 0);
    serve_to_play(SW'(1), '0, 1'b1);

    // Double miss: no score, serve direction kept.
    exp_q.push_back(mk(3'd3, SW'(1), '0, 1'b1, 2'b00, 1'b0, 1'b1));
    bus.miss_l = 1'b1;
    bus.miss_r = 1'b1;
    step(1);
    bus.miss_l = 1'b0;
    bus.miss_r = 1'b0;
    step(1);
    chk("let_state", 32'(bus.state_o), 1);
    serve_to_play(SW'(1), '0, 1'b1);

    // Three left misses: right player reaches WIN_SCORE.
    for (int i = 1; i <= WIN; i++) begin
      exp_q.push_back(mk(3'd3, SW'(1), SW'(i), 1'b0, 2'b00, 1'b0, 1'b1));
      bus.miss_l = 1'b1;
      step(1);
      bus.miss_l = 1'b0;
      step(1);
      if (i < WIN) serve_to_play(SW'(1), SW'(i), 1'b0);
    end
    chk("over_state", 32'(bus.state_o), 4);
    chk("over_winner", 32'(bus.winner), 2);
    chk("over_score_r", 32'(bus.score_r), 3);
    chk("over_ball_en", 32'(bus.ball_en), 0);

    // A miss in GAME_OVER changes nothing.
    bus.miss_r = 1'b1;
    step(1);
    bus.miss_r = 1'b0;
    step(1);
    chk("over_miss_score_l", 32'(bus.score_l), 1);
    chk("over_miss_state", 32'(bus.state_o), 4);

`ifdef PONG_AUTO_RESTART_EN
    exp_q.push_back(mk(3'd1, '0, '0, 1'b0, 2'b00, 1'b0, 1'b1));
    bus.tick = 1'b1;
    step(OT - 1);
    chk("auto_wait_state", 32'(bus.state_o), 4);
    step(1);
    bus.tick = 1'b0;
`else
    bus.tick = 1'b1;
    step(10);
    bus.tick = 1'b0;
    chk("over_hold_state", 32'(bus.state_o), 4);
    chk("over_hold_winner", 32'(bus.winner), 2);
    bus.start_n = 1'b1;
    step(1);
    exp_q.push_back(mk(3'd1, '0, '0, 1'b0, 2'b00, 1'b0, 1'b1));
    bus.start_n = 1'b0;
    step(1);
`endif
    chk("restart_state", 32'(bus.state_o), 1);
    chk("restart_winner", 32'(bus.winner), 0);
    chk("restart_score_r", 32'(bus.score_r), 0);
    serve_to_play('0, '0, 1'b0);

    // Score a point, then reset mid-serve with counter at 50.
    exp_q.push_back(mk(3'd3, SW'(1), '0, 1'b1, 2'b00, 1'b0, 1'b1));
    bus.miss_r = 1'b1;
    step(1);
    bus.miss_r = 1'b0;
    step(1);
    bus.tick = 1'b1;
    step(50);
    bus.tick = 1'b0;
    chk("pre_reset_score_l", 32'(bus.score_l), 1);
    chk("pre_reset_serve_dir", 32'(bus.serve_dir), 1);
    reset = 1'b1;
    #1;
    chk("async_rst_outputs", 32'(cur()), 32'(mk(3'd0, '0, '0, 1'b0, 2'b00, 1'b0, 1'b0)));
    step(2);
    reset = 1'b0;
    step(5);
    chk("held_start_no_match", 32'(bus.state_o), 0);
    chk("held_start_ball_en", 32'(bus.ball_en), 0);

    // A fresh press after release starts normally.
    bus.start_n = 1'b1;
    step(1);
    exp_q.push_back(mk(3'd1, '0, '0, 1'b0, 2'b00, 1'b0, 1'b1));
    bus.start_n = 1'b0;
    step(1);
    chk("final_start_state", 32'(bus.state_o), 1);
    step(2);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
Match sequencer for the pong game. Owns serve timing, scoring and win detection, and drives the paddle movers' recenter input (count2) and the ball mover's enable and serve direction. Sits between the player buttons and the paddle/ball movement blocks and runs in the same clock domain as them.

Parameters:
WIN_SCORE, 7, points needed to win the match (1..2^SCORE_W-1).
SCORE_W, 4, width of each score counter.
SERVE_TICKS, 120, number of frame ticks to wait in SERVE before the ball is released (>=1).
OVER_TICKS, 300, number of frame ticks in GAME_OVER before auto-restart (used only with the macro).

Ports:
clock  input  1  system clock (50 MHz).
reset  input  1  asynchronous, active-high reset.
tick  input  1  one-cycle frame strobe; all delay counting advances only on tick=1.
start_n  input  1  start button, active-low, already synchronised.
miss_l  input  1  one-cycle pulse: the ball passed the left paddle (point to right).
miss_r  input  1  one-cycle pulse: the ball passed the right paddle (point to left).
recenter  output  1  one-cycle pulse; connects to count2 of both paddle movers and to the ball-reset input.
ball_en  output  1  high while the ball may move.
serve_dir  output  1  0 = serve toward left player, 1 = serve toward right player.
score_l  output  SCORE_W  left player score.
score_r  output  SCORE_W  right player score.
winner  output  2  00 = none, 01 = left won, 10 = right won.
state_o  output  3  current state encoding, for debug/display.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, score_l=score_r=0, recenter=0, ball_en=0, serve_dir=0, winner=00, delay counter=0, start edge register=1.
- Start detect: falling edge of start_n (registered previous value was 1, current value is 0); start_n held low does not retrigger.
- States: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4.
- IDLE: ball_en=0. On a start edge: clear both scores, winner=00, serve_dir=0, pulse recenter for one cycle, load counter=0, go to SERVE.
- SERVE: ball_en=0. The counter increments on each tick. When a tick arrives with counter==SERVE_TICKS-1, go to PLAY and set ball_en=1 from the next cycle onward. miss_l and miss_r are ignored.
- PLAY: ball_en=1.
  - miss_l only: score_r+1, serve_dir=0 (serve toward the player who lost the point), go to POINT.
  - miss_r only: score_l+1, serve_dir=1, go to POINT.
  - miss_l and miss_r in the same cycle: no score change, serve_dir unchanged, go to POINT.
  - Start edges are ignored in PLAY.
- POINT: lasts exactly one cycle. ball_en=0 and recenter=1 for this cycle.
  - If score_l==WIN_SCORE: winner=01, go to GAME_OVER.
  - Else if score_r==WIN_SCORE: winner=10, go to GAME_OVER.
  - Otherwise clear the counter and go to SERVE.
- Scores saturate at WIN_SCORE and never wrap.
- GAME_OVER: ball_en=0; scores and winner are held. A start edge does the same as the IDLE start action and goes to SERVE.
- Latency: from a miss pulse to the recenter pulse is 1 cycle. ball_en falls in the cycle after the miss.
- Reset asserted mid-match returns the block to IDLE immediately; no recenter pulse is generated by reset. The paddle movers have their own reset.
- Unused state encodings (5..7) go to IDLE on the next clock.

Optional Feature:
PONG_AUTO_RESTART_EN:
- Defined: in GAME_OVER the counter counts ticks. When a tick arrives with counter==OVER_TICKS-1, the block does the start action automatically and goes to SERVE. A start edge still restarts early.
- Not defined: GAME_OVER waits indefinitely for a start edge, and OVER_TICKS is unused.

Test Plan:
- Reset, then start_n 1->0, then 120 ticks -> recenter pulses 1 cycle after the edge; ball_en=1 in the cycle after the 120th tick; state_o=2.
- In PLAY, pulse miss_r -> next cycle state_o=3, recenter=1, score_l=1, serve_dir=1; then SERVE with ball_en=0.
- In PLAY, pulse miss_l and miss_r in the same cycle -> scores unchanged, recenter pulses, back to SERVE.
- With WIN_SCORE=3, drive three miss_l points -> score_r=3, winner=10, state_o=4, ball_en stays 0; a further miss_r has no effect.
- Assert reset during SERVE with counter=50 -> all outputs return to their reset values asynchronously, state_o=0; holding start_n low through reset release does not start a match.
- With PONG_AUTO_RESTART_EN defined and OVER_TICKS=5: after a win, 5 ticks -> scores cleared, recenter pulse, state_o=1.
